alu_request_arbiter: RTL and testbench
======================================

Name: alu_request_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single ALU control unit and datapath among N_REQ requesters. Each requester supplies a 2-bit opcode, 3-bit ctrl and two operands. The arbiter grants one requester at a time, drives the ALU begin_op/opcode/ctrl/operand interface, waits for end_op, and returns the latched result with a one-cycle ack. It sits between client blocks (sequencer, test harness, host regs) and the ALU top.

Parameters:
N_REQ, 4, number of requesters (2..8); pointer width PTR_W = clog2(N_REQ)
DATA_W, 16, operand width
RES_W, 32, result width (holds full MUL product)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req  in  N_REQ  per-requester request level
req_opcode  in  2*N_REQ  flattened opcodes; requester i at [2i+1:2i]; 00 ADD/SUB, 01 MUL, 10 DIV, 11 SHIFT
req_ctrl  in  3*N_REQ  flattened micro-control; requester i at [3i+2:3i]
req_a  in  DATA_W*N_REQ  flattened operand A
req_b  in  DATA_W*N_REQ  flattened operand B
grant  out  N_REQ  one-hot owner, held from grant until end of RESP
ack  out  N_REQ  one-cycle pulse to owner; result valid in the same cycle
result  out  RES_W  last completed result, held until next RESP
busy  out  1  high in any state other than IDLE
alu_begin_op  out  1  begin pulse to ALU control unit
alu_opcode  out  2  latched opcode of owner
alu_ctrl  out  3  latched ctrl of owner
alu_a  out  DATA_W  latched operand A
alu_b  out  DATA_W  latched operand B
alu_end_op  in  1  completion pulse from ALU control unit
alu_result  in  RES_W  ALU result, valid when alu_end_op = 1

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, grant=0, ack=0, result=0, busy=0, alu_begin_op=0, alu_opcode/ctrl/a/b=0, owner=0.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs registered or decoded from state; no combinational path from req to ALU outputs.
- IDLE: if any req bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod N_REQ. At the clock edge: latch owner index; latch owner's opcode/ctrl/a/b into alu_* registers; set grant one-hot; rr_ptr <= (owner+1) mod N_REQ; go to ISSUE. If req=0, stay in IDLE; rr_ptr is unchanged.
- ISSUE: alu_begin_op=1 for exactly one cycle; go to WAIT unconditionally.
- WAIT: alu_begin_op=0. alu_opcode/ctrl/a/b are held stable. On alu_end_op=1: result <= alu_result, go to RESP. There is no timeout; WAIT holds indefinitely.
- RESP: ack[owner]=1 for one cycle; at the edge grant <= 0, go to IDLE.
- alu_end_op is ignored in IDLE, ISSUE and RESP; result does not change.
- Latency: req sampled at edge T, so grant is visible in cycle T+1 with alu_begin_op=1. ack appears in the cycle after the cycle in which alu_end_op is seen. Minimum repeat interval between grants is ISSUE+WAIT+RESP+IDLE.
- Operands are captured at grant. Later changes to req_* or a deasserted req do not affect the in-flight op; ack is still issued to the owner.
- A requester that holds req high after its ack is eligible again but goes behind every other pending requester (round-robin).
- Simultaneous requests: lowest index at or after rr_ptr wins; the other requests stay pending with no loss.
- Reset mid-operation returns to IDLE immediately and produces no ack. Reset of the ALU is the parent's responsibility; it uses the same reset net.
- busy = (state != IDLE).

Test Plan:
- Single op: req=0001, opcode 00, ctrl 000, a=5, b=3. Expect grant=0001 with alu_begin_op pulsed 1 cycle; model end_op with result 8 after 3 cycles; ack=0001 for 1 cycle; result=8 held; busy low after RESP.
- Contention: req=1010 held continuously from reset. Grants go to 1 then 3 then 1, alternating; ack order matches; no grant overlap.
- Round-robin: all four req held, each op MUL 7*9. Grants follow 0,1,2,3,0; each ack carries 63; rr_ptr wraps 3->0.
- Withdrawal: req0 asserted, granted, then dropped during WAIT. Op completes and ack0 still pulses with the DIV 100/7 quotient field of the model result.
- Spurious end_op: alu_end_op pulsed in IDLE and in ISSUE. No state change and result unchanged; a real end_op in WAIT still completes normally.
- Reset mid-WAIT: assert reset while in WAIT. All outputs are 0 immediately and no ack follows; after release a new req0 is served with rr_ptr=0.

Source files
------------

// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - round-robin arbiter sequencing N_REQ requesters onto one shared ALU
module alu_request_arbiter #(
   parameter int  N_REQ  = 4,
   parameter int  DATA_W = 16,
   parameter int  RES_W  = 32,
   localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [2*N_REQ-1:0]      req_opcode,
   input  logic [3*N_REQ-1:0]      req_ctrl,
   input  logic [DATA_W*N_REQ-1:0] req_a,
   input  logic [DATA_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        ack,
   output logic [RES_W-1:0]        result,
   output logic                    busy,
   output logic                    alu_begin_op,
   output logic [1:0]              alu_opcode,
   output logic [2:0]              alu_ctrl,
   output logic [DATA_W-1:0]       alu_a,
   output logic [DATA_W-1:0]       alu_b,
   input  logic                    alu_end_op,
   input  logic [RES_W-1:0]        alu_result
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state;
   logic [PTR_W-1:0]    r_rr_ptr;
   logic [PTR_W-1:0]    r_owner;
   logic [N_REQ-1:0]    r_grant;
   logic [N_REQ-1:0]    r_ack;
   logic [RES_W-1:0]    r_result;
   logic                r_begin_op;
   logic [1:0]          r_opcode;
   logic [2:0]          r_ctrl;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;

   logic [2*N_REQ-1:0]  w_req_dbl;
   logic [N_REQ-1:0]    w_req_rot;
   logic                w_found;
   logic [PTR_W-1:0]    w_offset;
   logic [PTR_W:0]      w_sum;
   logic [PTR_W-1:0]    w_pick_idx;
   logic [PTR_W-1:0]    w_next_ptr;
   logic [1:0]          w_sel_opcode;
   logic [2:0]          w_sel_ctrl;
   logic [DATA_W-1:0]   w_sel_a;
   logic [DATA_W-1:0]   w_sel_b;

   // Rotate so bit 0 is the requester at rr_ptr; lowest set bit is then the winner.
   assign w_req_dbl = {req, req};
   assign w_req_rot = w_req_dbl[r_rr_ptr +: N_REQ];

   always_comb begin
      w_found  = 1'b0;
      w_offset = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && w_req_rot[k]) begin
            w_found  = 1'b1;
            w_offset = PTR_W'(k);
         end
      end
   end

   always_comb begin
      w_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
         w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      w_pick_idx = w_sum[PTR_W-1:0];
      w_next_ptr = (w_pick_idx == PTR_W'(N_REQ-1)) ? '0 : w_pick_idx + PTR_W'(1);
   end

   always_comb begin
      w_sel_opcode = '0;
      w_sel_ctrl   = '0;
      w_sel_a      = '0;
      w_sel_b      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick_idx == PTR_W'(i)) begin
            w_sel_opcode = req_opcode[2*i +: 2];
            w_sel_ctrl   = req_ctrl[3*i +: 3];
            w_sel_a      = req_a[DATA_W*i +: DATA_W];
            w_sel_b      = req_b[DATA_W*i +: DATA_W];
         end
      end
   end

   // Operands are captured once at grant; the ALU sees only these registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_grant    <= '0;
         r_ack      <= '0;
         r_result   <= '0;
         r_begin_op <= 1'b0;
         r_opcode   <= '0;
         r_ctrl     <= '0;
         r_a        <= '0;
         r_b        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_owner    <= w_pick_idx;
                  r_grant    <= N_REQ'(1) << w_pick_idx;
                  r_rr_ptr   <= w_next_ptr;
                  r_opcode   <= w_sel_opcode;
                  r_ctrl     <= w_sel_ctrl;
                  r_a        <= w_sel_a;
                  r_b        <= w_sel_b;
                  r_begin_op <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_begin_op <= 1'b0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (alu_end_op) begin
                  r_result <= alu_result;
                  r_ack    <= N_REQ'(1) << r_owner;
                  r_state  <= S_RESP;
               end
            end
            S_RESP: begin
               r_ack   <= '0;
               r_grant <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant        = r_grant;
   assign ack          = r_ack;
   assign result       = r_result;
   assign busy         = (r_state != S_IDLE);
   assign alu_begin_op = r_begin_op;
   assign alu_opcode   = r_opcode;
   assign alu_ctrl     = r_ctrl;
   assign alu_a        = r_a;
   assign alu_b        = r_b;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb/tb_alu_request_arbiter.sv - directed self-checking bench for alu_request_arbiter
module tb_alu_request_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 16;
   localparam int RES_W  = 32;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_REQ-1:0]        req;
   logic [2*N_REQ-1:0]      req_opcode;
   logic [3*N_REQ-1:0]      req_ctrl;
   logic [DATA_W*N_REQ-1:0] req_a;
   logic [DATA_W*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]        grant;
   logic [N_REQ-1:0]        ack;
   logic [RES_W-1:0]        result;
   logic                    busy;
   logic                    alu_begin_op;
   logic [1:0]              alu_opcode;
   logic [2:0]              alu_ctrl;
   logic [DATA_W-1:0]       alu_a;
   logic [DATA_W-1:0]       alu_b;
   logic                    alu_end_op;
   logic [RES_W-1:0]        alu_result;

   int vectors     = 0;
   int miscompares = 0;

   alu_request_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_opcode   (req_opcode),
      .req_ctrl     (req_ctrl),
      .req_a        (req_a),
      .req_b        (req_b),
      .grant        (grant),
      .ack          (ack),
      .result       (result),
      .busy         (busy),
      .alu_begin_op (alu_begin_op),
      .alu_opcode   (alu_opcode),
      .alu_ctrl     (alu_ctrl),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_end_op   (alu_end_op),
      .alu_result   (alu_result)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] ct,
                          input logic [15:0] a, input logic [15:0] b);
      req_opcode[2*i +: 2]           = op;
      req_ctrl[3*i +: 3]             = ct;
      req_a[DATA_W*i +: DATA_W]      = a;
      req_b[DATA_W*i +: DATA_W]      = b;
   endtask

   task automatic wait_begin(input string tag);
      int n = 0;
      while (alu_begin_op !== 1'b1 && n < 8) begin
         cyc();
         n++;
      end
      chk({tag, " begin_op"}, 64'(alu_begin_op), 64'd1);
   endtask

   task automatic check_issue(input string tag, input int owner, input logic [1:0] op,
                              input logic [2:0] ct, input logic [15:0] a, input logic [15:0] b);
      logic [N_REQ-1:0] oh;
      oh = N_REQ'(1) << owner;
      chk({tag, " grant"},  64'(grant), 64'(oh));
      chk({tag, " busy"},   64'(busy), 64'd1);
      chk({tag, " opcode"}, 64'(alu_opcode), 64'(op));
      chk({tag, " ctrl"},   64'(alu_ctrl), 64'(ct));
      chk({tag, " a"},      64'(alu_a), 64'(a));
      chk({tag, " b"},      64'(alu_b), 64'(b));
   endtask

   task automatic finish_op(input string tag, input int owner, input logic [31:0] res, input int dly);
      logic [N_REQ-1:0] oh;
      oh = N_REQ'(1) << owner;
      repeat (dly) cyc();
      chk({tag, " begin_low"}, 64'(alu_begin_op), 64'd0);
      chk({tag, " no_early_ack"}, 64'(ack), 64'd0);
      alu_end_op = 1'b1;
      alu_result = res;
      cyc();
      alu_end_op = 1'b0;
      alu_result = 32'h5A5A_5A5A;
      chk({tag, " ack"},        64'(ack), 64'(oh));
      chk({tag, " result"},     64'(result), 64'(res));
      chk({tag, " grant_held"}, 64'(grant), 64'(oh));
      cyc();
      chk({tag, " ack_pulse"},  64'(ack), 64'd0);
      chk({tag, " grant_drop"}, 64'(grant), 64'd0);
      chk({tag, " busy_low"},   64'(busy), 64'd0);
      chk({tag, " result_held"}, 64'(result), 64'(res));
   endtask

   initial begin
      reset      = 1'b1;
      req        = '0;
      req_opcode = '0;
      req_ctrl   = '0;
      req_a      = '0;
      req_b      = '0;
      alu_end_op = 1'b0;
      alu_result = '0;
      repeat (2) cyc();

      chk("rst grant",  64'(grant), 64'd0);
      chk("rst ack",    64'(ack), 64'd0);
      chk("rst result", 64'(result), 64'd0);
      chk("rst busy",   64'(busy), 64'd0);
      chk("rst begin",  64'(alu_begin_op), 64'd0);
      chk("rst a",      64'(alu_a), 64'd0);
      reset = 1'b0;
      cyc();

      // single op: ADD 5+3
      set_req(0, 2'b00, 3'b000, 16'd5, 16'd3);
      req = 4'b0001;
      wait_begin("single");
      check_issue("single", 0, 2'b00, 3'b000, 16'd5, 16'd3);
      req = 4'b0000;
      finish_op("single", 0, 32'd8, 3);

      // contention: req=1010 from reset
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      set_req(1, 2'b00, 3'b001, 16'd40, 16'd2);
      set_req(3, 2'b11, 3'b010, 16'h00F0, 16'd4);
      req = 4'b1010;
      wait_begin("cont0");
      check_issue("cont0", 1, 2'b00, 3'b001, 16'd40, 16'd2);
      finish_op("cont0", 1, 32'd38, 2);
      wait_begin("cont1");
      check_issue("cont1", 3, 2'b11, 3'b010, 16'h00F0, 16'd4);
      finish_op("cont1", 3, 32'h0000_0F00, 2);
      wait_begin("cont2");
      check_issue("cont2", 1, 2'b00, 3'b001, 16'd40, 16'd2);
      finish_op("cont2", 1, 32'd38, 2);
      req = 4'b0000;

      // round robin: all four MUL 7*9, expect owners 0,1,2,3,0
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < N_REQ; i++) set_req(i, 2'b01, 3'b000, 16'd7, 16'd9);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_begin($sformatf("rr%0d", k));
         check_issue($sformatf("rr%0d", k), k % 4, 2'b01, 3'b000, 16'd7, 16'd9);
         finish_op($sformatf("rr%0d", k), k % 4, 32'd63, 1);
      end
      req = 4'b0000;

      // withdrawal: DIV 100/7, req dropped during WAIT; rr_ptr=1 so scan wraps to 0
      set_req(0, 2'b10, 3'b000, 16'd100, 16'd7);
      req = 4'b0001;
      wait_begin("wd");
      check_issue("wd", 0, 2'b10, 3'b000, 16'd100, 16'd7);
      cyc();
      req = 4'b0000;
      set_req(0, 2'b00, 3'b000, 16'd0, 16'd0);
      cyc();
      chk("wd a_held",      64'(alu_a), 64'd100);
      chk("wd opcode_held", 64'(alu_opcode), 64'd2);
      finish_op("wd", 0, 32'h0002_000E, 1);
      chk("wd quotient", 64'(result[15:0]), 64'd14);

      // spurious end_op in IDLE and in ISSUE
      alu_end_op = 1'b1;
      alu_result = 32'hDEAD_BEEF;
      cyc();
      alu_end_op = 1'b0;
      chk("spur idle result", 64'(result), 64'h0002_000E);
      chk("spur idle busy",   64'(busy), 64'd0);
      set_req(2, 2'b00, 3'b000, 16'd1, 16'd1);
      req = 4'b0100;
      wait_begin("spur");
      check_issue("spur", 2, 2'b00, 3'b000, 16'd1, 16'd1);
      req = 4'b0000;
      alu_end_op = 1'b1;
      alu_result = 32'h0000_0BAD;
      cyc();
      alu_end_op = 1'b0;
      chk("spur issue result", 64'(result), 64'h0002_000E);
      chk("spur issue ack",    64'(ack), 64'd0);
      chk("spur issue busy",   64'(busy), 64'd1);
      chk("spur issue grant",  64'(grant), 64'b0100);
      finish_op("spur", 2, 32'd2, 1);

      // reset mid-WAIT; rr_ptr=3 so requester 1 wins next
      set_req(1, 2'b01, 3'b011, 16'h0011, 16'h0022);
      req = 4'b0010;
      wait_begin("rstw");
      check_issue("rstw", 1, 2'b01, 3'b011, 16'h0011, 16'h0022);
      req = 4'b0000;
      cyc();
      reset = 1'b1;
      #1;
      chk("rstw grant",  64'(grant), 64'd0);
      chk("rstw ack",    64'(ack), 64'd0);
      chk("rstw busy",   64'(busy), 64'd0);
      chk("rstw begin",  64'(alu_begin_op), 64'd0);
      chk("rstw opcode", 64'(alu_opcode), 64'd0);
      chk("rstw ctrl",   64'(alu_ctrl), 64'd0);
      chk("rstw a",      64'(alu_a), 64'd0);
      chk("rstw b",      64'(alu_b), 64'd0);
      chk("rstw result", 64'(result), 64'd0);
      alu_end_op = 1'b1;
      alu_result = 32'hFFFF_FFFF;
      cyc();
      alu_end_op = 1'b0;
      cyc();
      chk("rstw no_ack", 64'(ack), 64'd0);
      reset = 1'b0;
      // req0 and req3: only rr_ptr=0 picks requester 0
      set_req(0, 2'b00, 3'b000, 16'd3, 16'd4);
      set_req(3, 2'b00, 3'b000, 16'd9, 16'd9);
      req = 4'b1001;
      cyc();
      chk("rstw still_no_ack", 64'(ack), 64'd0);
      wait_begin("post");
      check_issue("post", 0, 2'b00, 3'b000, 16'd3, 16'd4);
      req = 4'b0000;
      finish_op("post", 0, 32'd7, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
